dmem_arbiter: RTL

Data-memory access controller between the pipeline's MEM stage and the data block RAM.
- Shares the single-port RAM between the CPU and a secondary word-only requester (boot loader / debug port).
- Generates byte-lane write enables and store-data replication.
- Sequences the RAM's 1-cycle read latency, stalling the pipeline until load data is back.
- Aligns and extends load data per `dm_ctrl`.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 57 +++++
 rtl/dmem_lane_fmt.sv | 44 ++++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access-type encodings,
// FSM states and the CPU misalignment predicate.
package dmem_arbiter_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        EXT_RD = 2'd2
    } state_t;

    // Byte accesses are never misaligned; unknown encodings behave as words.
    function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] lo);
        case (ctrl)
            DM_HALF, DM_HALF_U: return lo[0];
            DM_BYTE, DM_BYTE_U: return 1'b0;
            default:            return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, secondary-requester and RAM signals around dmem_arbiter.
// cpu_misalign exists only when DMEM_MISALIGN_CHK_EN is defined.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12
);
    // Handshakes: a requester holds req (and its fields) until accepted; the CPU
    // is accepted in the cycle it sees cpu_stall=0, ext in the cycle ext_gnt=1.
    // Read data is valid only in the single cycle its rvalid pulse is high.
    logic              cpu_req;
    logic              cpu_we;
    logic [2:0]        cpu_dm_ctrl;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;
    logic              cpu_rvalid;
`ifdef DMEM_MISALIGN_CHK_EN
    logic              cpu_misalign;
`endif
    logic              ext_req;
    logic              ext_we;
    logic [31:0]       ext_addr;
    logic [31:0]       ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [31:0]       ext_rdata;
    logic              ram_en;
    logic [3:0]        ram_wea;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    modport slave (
`ifdef DMEM_MISALIGN_CHK_EN
        output cpu_misalign,
`endif
        input  cpu_req, cpu_we, cpu_dm_ctrl, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output ram_en, ram_wea, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
`ifdef DMEM_MISALIGN_CHK_EN
        input  cpu_misalign,
`endif
        output cpu_req, cpu_we, cpu_dm_ctrl, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  ram_en, ram_wea, ram_addr, ram_din,
        output ram_dout
    );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: store byte enables and data replication,
// load lane selection with sign/zero extension.
module dmem_lane_fmt
    import dmem_arbiter_pkg::*;
(
    input  logic [2:0]  dm_ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wea,
    output logic [31:0] din,
    output logic [31:0] rdata
);
    logic [15:0] half;
    logic [7:0]  lane_b;

    always_comb begin
        half = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (addr_lo)
            2'd0:    lane_b = rword[7:0];
            2'd1:    lane_b = rword[15:8];
            2'd2:    lane_b = rword[23:16];
            default: lane_b = rword[31:24];
        endcase

        wea   = 4'b1111;
        din   = wdata;
        rdata = rword;
        case (dm_ctrl)
            DM_HALF, DM_HALF_U: begin
                wea   = addr_lo[1] ? 4'b1100 : 4'b0011;
                din   = {2{wdata[15:0]}};
                rdata = (dm_ctrl == DM_HALF) ? {{16{half[15]}}, half} : {16'h0, half};
            end
            DM_BYTE, DM_BYTE_U: begin
                wea   = 4'b0001 << addr_lo;
                din   = {4{wdata[7:0]}};
                rdata = (dm_ctrl == DM_BYTE) ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data RAM between the CPU MEM stage and a word-only
// secondary requester. Optional misaligned-access blocking: DMEM_MISALIGN_CHK_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic          clk,
    input  logic          rstn,
    dmem_arbiter_if.slave bus,
    output state_t        dbg_state
);
    localparam int RUN_W = $clog2(MAX_CPU_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);

    state_t           state, state_nx;
    logic [RUN_W-1:0] run_cnt, run_cnt_nx;
    logic [2:0]       rd_ctrl;
    logic [1:0]       rd_lo;
    logic             cpu_pick, cpu_grant, ext_grant, done, misalign;
    logic [2:0]       fmt_ctrl;
    logic [1:0]       fmt_lo;
    logic [3:0]       fmt_wea;
    logic [31:0]      fmt_din, fmt_rdata;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.ext_addr[31:ADDR_W+2],
                                bus.ext_addr[1:0]};
    assign dbg_state = state;

    // One formatter serves both directions: live CPU fields while issuing,
    // the fields captured at issue while the load returns.
    assign fmt_ctrl = (state == CPU_RD) ? rd_ctrl : bus.cpu_dm_ctrl;
    assign fmt_lo   = (state == CPU_RD) ? rd_lo   : bus.cpu_addr[1:0];

    dmem_lane_fmt u_fmt (
        .dm_ctrl (fmt_ctrl),
        .addr_lo (fmt_lo),
        .wdata   (bus.cpu_wdata),
        .rword   (bus.ram_dout),
        .wea     (fmt_wea),
        .din     (fmt_din),
        .rdata   (fmt_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            run_cnt <= '0;
            rd_ctrl <= '0;
            rd_lo   <= '0;
        end else begin
            state   <= state_nx;
            run_cnt <= run_cnt_nx;
            if (cpu_grant && !bus.cpu_we) begin
                rd_ctrl <= bus.cpu_dm_ctrl;
                rd_lo   <= bus.cpu_addr[1:0];
            end
        end
    end

    always_comb begin
        state_nx       = state;
        run_cnt_nx     = run_cnt;
        cpu_pick       = 1'b0;
        cpu_grant      = 1'b0;
        ext_grant      = 1'b0;
        done           = 1'b0;
        misalign       = 1'b0;
        bus.cpu_stall  = 1'b0;
        bus.cpu_rdata  = '0;
        bus.cpu_rvalid = 1'b0;
        bus.ext_gnt    = 1'b0;
        bus.ext_rvalid = 1'b0;
        bus.ext_rdata  = '0;
        bus.ram_en     = 1'b0;
        bus.ram_wea    = '0;
        bus.ram_addr   = '0;
        bus.ram_din    = '0;

        // Outputs are held at zero for as long as reset is asserted.
        if (rstn) begin
            case (state)
                IDLE: begin
                    cpu_pick = bus.cpu_req && !(bus.ext_req && run_cnt == RUN_MAX);
`ifdef DMEM_MISALIGN_CHK_EN
                    misalign = cpu_pick && is_misaligned(bus.cpu_dm_ctrl, bus.cpu_addr[1:0]);
`endif
                    cpu_grant = cpu_pick && !misalign;
                    ext_grant = !cpu_pick && bus.ext_req;
                    done      = misalign || (cpu_grant && bus.cpu_we);
                    if (cpu_grant) begin
                        bus.ram_en   = 1'b1;
                        bus.ram_addr = bus.cpu_addr[ADDR_W+1:2];
                        if (bus.cpu_we) begin
                            bus.ram_wea = fmt_wea;
                            bus.ram_din = fmt_din;
                        end else begin
                            state_nx = CPU_RD;
                        end
                    end else if (ext_grant) begin
                        bus.ext_gnt  = 1'b1;
                        bus.ram_en   = 1'b1;
                        bus.ram_addr = bus.ext_addr[ADDR_W+1:2];
                        if (bus.ext_we) begin
                            bus.ram_wea = 4'b1111;
                            bus.ram_din = bus.ext_wdata;
                        end else begin
                            state_nx = EXT_RD;
                        end
                    end
                end
                CPU_RD: begin
                    // A flushed load still drains the RAM but is not reported.
                    done           = 1'b1;
                    bus.cpu_rvalid = bus.cpu_req;
                    bus.cpu_rdata  = bus.cpu_req ? fmt_rdata : '0;
                    state_nx       = IDLE;
                end
                EXT_RD: begin
                    bus.ext_rvalid = 1'b1;
                    bus.ext_rdata  = bus.ram_dout;
                    state_nx       = IDLE;
                end
                default: state_nx = IDLE;
            endcase

            if (!bus.ext_req || ext_grant) begin
                run_cnt_nx = '0;
            end else if (cpu_grant) begin
                run_cnt_nx = run_cnt + 1'b1;
            end
            bus.cpu_stall = bus.cpu_req && !done;
        end
`ifdef DMEM_MISALIGN_CHK_EN
        bus.cpu_misalign = misalign;
`endif
    end

endmodule
